// File: rtl/q16_dot_accum_if.sv
// Handshake bundle for the Q16.16 dot-product accumulator: product stream in, result stream out.
interface q16_dot_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/q16_dot_accum.sv
// Sums VEC_LEN signed Q16.16 products with per-step saturation and a sticky saturation flag.
module q16_dot_accum #(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  q16_dot_accum_if.slave  bus
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                out_sat_q, out_sat_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                xfer;
  logic                last_elem;
  logic [DATA_W:0]     sum_ext;
  logic                ovf;
  logic [DATA_W-1:0]   sum_sat;

  assign accept    = bus.in_valid && in_ready_q;
  assign xfer      = out_valid_q && bus.out_ready;
  assign last_elem = (cnt_q == CNT_W'(VEC_LEN - 1));

  // Signed overflow shows up as the two top bits of the sign-extended sum disagreeing
  assign sum_ext = {acc_q[DATA_W-1], acc_q} + {bus.in_data[DATA_W-1], bus.in_data};
  assign ovf     = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
  assign sum_sat = ovf ? (acc_q[DATA_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                       : sum_ext[DATA_W-1:0];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (accept && last_elem) state_d = ST_HOLD;
      ST_HOLD:  if (xfer)                state_d = ST_ACCUM;
      default:                           state_d = ST_ACCUM;
    endcase
  end

  // Handshake flags follow the upcoming state so they leave the flops with no input path
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_d)
      ST_ACCUM: in_ready_d  = 1'b1;
      ST_HOLD:  out_valid_d = 1'b1;
      default:  in_ready_d  = 1'b1;
    endcase
  end

  // Accumulator datapath
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (accept) begin
      acc_d = sum_sat;
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | ovf;
      if (last_elem) begin
        out_data_d = sum_sat;
        out_sat_d  = sat_q | ovf;
      end
    end
    if (xfer) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_q16_dot_accum.sv
// Randomized and directed checks of q16_dot_accum against a plain-arithmetic reference model.
module tb_q16_dot_accum;

  localparam int unsigned VLEN = 4;

  logic clk;
  logic rst;

  q16_dot_accum_if bus_if ();

  q16_dot_accum #(.VEC_LEN(VLEN), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_xfer   = 0;
  bit rand_rdy = 1'b0;
  bit acc_seen = 1'b0;

  // Reference model state
  longint      mdl_sum;
  int          mdl_cnt;
  bit          mdl_sat;
  logic [31:0] exp_data_q[$];
  bit          exp_sat_q[$];
  bit          lat_pend;
  bit          hold_pend;
  logic [31:0] hold_data;
  bit          hold_sat;
  logic [31:0] last_data;
  logic        last_sat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Clamp to the Q16.16 range after every single add
  function automatic void model_add(input logic [31:0] d);
    longint s;
    s = mdl_sum + longint'($signed(d));
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647;
      mdl_sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648;
      mdl_sat = 1'b1;
    end
    mdl_sum = s;
  endfunction

  task automatic model_clear();
    mdl_sum = 0;
    mdl_cnt = 0;
    mdl_sat = 1'b0;
    exp_data_q.delete();
    exp_sat_q.delete();
    lat_pend  = 1'b0;
    hold_pend = 1'b0;
  endtask

  // Observe the bus mid-cycle and score against the model
  task automatic sample();
    acc_seen = 1'b0;
    if (rst) begin
      model_clear();
      return;
    end
    check_eq("rdy_vs_vld", 32'(bus_if.in_ready), 32'(!bus_if.out_valid));
    if (lat_pend) begin
      check_eq("out_latency", 32'(bus_if.out_valid), 32'd1);
      lat_pend = 1'b0;
    end
    if (hold_pend) begin
      check_eq("hold_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("hold_data", bus_if.out_data, hold_data);
      check_eq("hold_sat", 32'(bus_if.out_sat), 32'(hold_sat));
    end
    hold_pend = bus_if.out_valid && !bus_if.out_ready;
    hold_data = bus_if.out_data;
    hold_sat  = bus_if.out_sat;
    if (bus_if.in_valid && bus_if.in_ready) begin
      acc_seen = 1'b1;
      n_acc++;
      model_add(bus_if.in_data);
      mdl_cnt++;
      if (mdl_cnt == int'(VLEN)) begin
        exp_data_q.push_back(32'(mdl_sum));
        exp_sat_q.push_back(mdl_sat);
        mdl_sum  = 0;
        mdl_cnt  = 0;
        mdl_sat  = 1'b0;
        lat_pend = 1'b1;
      end
    end
    if (bus_if.out_valid && bus_if.out_ready) begin
      n_xfer++;
      last_data = bus_if.out_data;
      last_sat  = bus_if.out_sat;
      check_eq("exp_avail", 32'(exp_data_q.size() != 0), 32'd1);
      if (exp_data_q.size() != 0) begin
        check_eq("model_data", bus_if.out_data, exp_data_q.pop_front());
        check_eq("model_sat", 32'(bus_if.out_sat), 32'(exp_sat_q.pop_front()));
      end
    end
  endtask

  // One clock: sample at the falling edge, then drive just after the rising edge
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_rdy) bus_if.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed(input logic [31:0] d, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    bus_if.in_valid = 1'b0;
    repeat (gaps) tick();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc_seen) break;
    end
    if (!acc_seen) check_eq("accept_timeout", 32'(acc_seen), 32'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_xfer(input int start);
    for (int i = 0; i < 60; i++) begin
      if (n_xfer != start) break;
      tick();
    end
    check_eq("xfer_count", 32'(n_xfer - start), 32'd1);
  endtask

  function automatic logic [31:0] rand_q16();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) r = 32'($signed(r[23:0]));
    return r;
  endfunction

  initial begin
    int start;
    int acc0;
    model_clear();
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_out_data", bus_if.out_data, 32'h0);
    check_eq("rst_out_sat", 32'(bus_if.out_sat), 32'd0);
    check_eq("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

    // Back-to-back 1.0 x4
    bus_if.out_ready = 1'b1;
    start = n_xfer;
    repeat (VLEN) feed(32'h0001_0000, 0);
    check_eq("t2_valid_next", 32'(bus_if.out_valid), 32'd1);
    wait_xfer(start);
    check_eq("t2_data", last_data, 32'h0004_0000);
    check_eq("t2_sat", 32'(last_sat), 32'd0);

    // Positive saturation mid-vector, then recovery
    start = n_xfer;
    feed(32'h7FFF_0000, 0); feed(32'h0002_0000, 0); feed(32'hFFFF_0000, 0); feed(32'h0, 0);
    wait_xfer(start);
    check_eq("t3_data", last_data, 32'h7FFE_FFFF);
    check_eq("t3_sat", 32'(last_sat), 32'd1);

    // Negative saturation, then sticky flag clears on the next vector
    start = n_xfer;
    feed(32'h8001_0000, 0); feed(32'hFFFE_0000, 0); feed(32'h0, 0); feed(32'h0, 0);
    wait_xfer(start);
    check_eq("t4_data", last_data, 32'h8000_0000);
    check_eq("t4_sat", 32'(last_sat), 32'd1);
    start = n_xfer;
    repeat (VLEN) feed(32'h0001_0000, 1);
    wait_xfer(start);
    check_eq("t4b_data", last_data, 32'h0004_0000);
    check_eq("t4b_sat", 32'(last_sat), 32'd0);

    // Backpressure in HOLD with a pending input
    bus_if.out_ready = 1'b0;
    start = n_xfer;
    feed(32'h0001_0000, 0); feed(32'h0002_0000, 0); feed(32'h0003_0000, 0); feed(32'h0004_0000, 0);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h1234_5678;
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_in_ready", 32'(bus_if.in_ready), 32'd0);
      check_eq("t5_out_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("t5_out_data", bus_if.out_data, 32'h000A_0000);
    end
    check_eq("t5_no_accept", 32'(n_acc - acc0), 32'd0);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    repeat (3) tick();
    check_eq("t5_one_xfer", 32'(n_xfer - start), 32'd1);
    check_eq("t5_data", last_data, 32'h000A_0000);
    check_eq("t5_valid_drop", 32'(bus_if.out_valid), 32'd0);

    // Reset mid-vector discards the partial sum
    bus_if.out_ready = 1'b1;
    feed(32'h0001_0000, 0); feed(32'h0001_0000, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_in_ready", 32'(bus_if.in_ready), 32'd1);
    start = n_xfer;
    repeat (VLEN) feed(32'h0001_0000, 3);
    wait_xfer(start);
    check_eq("t6_data", last_data, 32'h0004_0000);
    check_eq("t6_sat", 32'(last_sat), 32'd0);

    // Random vectors with gaps and random backpressure
    rand_rdy = 1'b1;
    for (int v = 0; v < 30; v++) begin
      start = n_xfer;
      for (int e = 0; e < int'(VLEN); e++) feed(rand_q16(), 2);
      wait_xfer(start);
    end
    rand_rdy = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) tick();
    check_eq("final_exp_empty", 32'(exp_data_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
